// File: rtl/dw03_bictr_decode_chk_if.sv
// rtl/dw03_bictr_decode_chk_if.sv - snooped counter stimulus and DUT outputs seen by the checker
interface dw03_bictr_decode_chk_if #(
   parameter int WIDTH = 8
);
   logic                  cen;
   logic                  count_up_dwn;
   logic                  load;
   logic [WIDTH-1:0]      data_preset;
   logic [WIDTH-1:0]      dut_count;
   logic [2**WIDTH-1:0]   dut_count_dec;
   logic                  dut_tercnt;

   modport master (
      output cen, count_up_dwn, load, data_preset,
      output dut_count, dut_count_dec, dut_tercnt
   );

   modport slave (
      input cen, count_up_dwn, load, data_preset,
      input dut_count, dut_count_dec, dut_tercnt
   );
endinterface

// File: rtl/dw03_bictr_decode_chk.sv
// rtl/dw03_bictr_decode_chk.sv - shadow-model checker for an up/down counter with one-hot decode
module dw03_bictr_decode_chk #(
   parameter int WIDTH  = 8,
   parameter int ERRW   = 16,
   parameter int RESYNC = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dw03_bictr_decode_chk_if.slave bus,
   output logic                 armed,
   output logic                 err_count,
   output logic                 err_dec,
   output logic                 err_tercnt,
   output logic                 err_seen,
   output logic [ERRW-1:0]      err_cnt,
   output logic [WIDTH-1:0]     first_exp,
   output logic [WIDTH-1:0]     first_got
);
   localparam int DECW = 2**WIDTH;

   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] shadow_nxt;
   logic [WIDTH-1:0] base;
   logic [DECW-1:0]  exp_dec;
   logic             exp_tercnt;
   logic             mis_count;
   logic             mis_dec;
   logic             mis_tercnt;
   logic             mis_any;

   always_comb begin
      exp_dec    = {{(DECW-1){1'b0}}, 1'b1} << shadow;
      exp_tercnt = bus.count_up_dwn ? (shadow == {WIDTH{1'b1}}) : (shadow == {WIDTH{1'b0}});
      mis_count  = armed && (bus.dut_count != shadow);
      mis_dec    = armed && (bus.dut_count_dec != exp_dec);
      mis_tercnt = armed && (bus.dut_tercnt != exp_tercnt);
      mis_any    = mis_count || mis_dec || mis_tercnt;

      // Resync: step from the DUT's value so one glitch produces a single error.
      base = ((RESYNC != 0) && mis_count) ? bus.dut_count : shadow;

      shadow_nxt = base;
      if (bus.load) begin
         shadow_nxt = bus.data_preset;
      end else if (bus.cen) begin
         if (bus.count_up_dwn) begin
            shadow_nxt = base + WIDTH'(1);
         end else begin
            shadow_nxt = base - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow     <= '0;
         armed      <= 1'b0;
         err_count  <= 1'b0;
         err_dec    <= 1'b0;
         err_tercnt <= 1'b0;
         err_seen   <= 1'b0;
         err_cnt    <= '0;
         first_exp  <= '0;
         first_got  <= '0;
      end else begin
         armed      <= 1'b1;
         shadow     <= shadow_nxt;
         err_count  <= mis_count;
         err_dec    <= mis_dec;
         err_tercnt <= mis_tercnt;
         if (mis_any) begin
            err_seen <= 1'b1;
            if (err_cnt != {ERRW{1'b1}}) begin
               err_cnt <= err_cnt + ERRW'(1);
            end
            if (!err_seen) begin
               first_exp <= shadow;
               first_got <= bus.dut_count;
            end
         end
      end
   end
endmodule

// File: tb/tb_dw03_bictr_decode_chk.sv
// tb/tb_dw03_bictr_decode_chk.sv - bench for dw03_bictr_decode_chk with RESYNC=1 and RESYNC=0 instances
module tb_dw03_bictr_decode_chk;
   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   dw03_bictr_decode_chk_if #(.WIDTH(W)) bus ();

   logic        armed_o [2];
   logic        ec_o    [2];
   logic        ed_o    [2];
   logic        et_o    [2];
   logic        seen_o  [2];
   logic [15:0] cnt_o   [2];
   logic [W-1:0] fe_o   [2];
   logic [W-1:0] fg_o   [2];

   dw03_bictr_decode_chk #(.WIDTH(W), .ERRW(16), .RESYNC(1)) u_rs (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .armed(armed_o[0]), .err_count(ec_o[0]), .err_dec(ed_o[0]), .err_tercnt(et_o[0]),
      .err_seen(seen_o[0]), .err_cnt(cnt_o[0]), .first_exp(fe_o[0]), .first_got(fg_o[0])
   );

   dw03_bictr_decode_chk #(.WIDTH(W), .ERRW(16), .RESYNC(0)) u_fr (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .armed(armed_o[1]), .err_count(ec_o[1]), .err_dec(ed_o[1]), .err_tercnt(et_o[1]),
      .err_seen(seen_o[1]), .err_cnt(cnt_o[1]), .first_exp(fe_o[1]), .first_got(fg_o[1])
   );

   int total = 0;
   int bad   = 0;
   int dut_ctr = 0;
   bit bad_dec = 0;
   bit inv_t   = 0;

   int m_sh[2], m_arm[2], m_ec[2], m_ed[2], m_et[2], m_seen[2], m_cnt[2], m_fe[2], m_fg[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit c, input bit u, input bit l, input int p);
      bus.cen          = c;
      bus.count_up_dwn = u;
      bus.load         = l;
      bus.data_preset  = p[W-1:0];
   endtask

   // Reference: the counter-checker rules applied with integer arithmetic mod 16.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         int dc, dec, tc, expt, mc, md, mt, any, base;
         if (!rst_n) begin
            m_sh[i] = 0; m_arm[i] = 0; m_ec[i] = 0; m_ed[i] = 0; m_et[i] = 0;
            m_seen[i] = 0; m_cnt[i] = 0; m_fe[i] = 0; m_fg[i] = 0;
         end else begin
            dc   = int'(bus.dut_count);
            dec  = int'(bus.dut_count_dec);
            tc   = int'(bus.dut_tercnt);
            expt = bus.count_up_dwn ? (m_sh[i] == 15) : (m_sh[i] == 0);
            mc   = m_arm[i] && (dc != m_sh[i]);
            md   = m_arm[i] && (dec != (1 << m_sh[i]));
            mt   = m_arm[i] && (tc != expt);
            any  = mc || md || mt;
            base = (i == 0 && mc) ? dc : m_sh[i];
            if (any && !m_seen[i]) begin
               m_fe[i] = m_sh[i];
               m_fg[i] = dc;
            end
            if (any) m_seen[i] = 1;
            if (any && m_cnt[i] < 65535) m_cnt[i]++;
            m_ec[i] = mc; m_ed[i] = md; m_et[i] = mt;
            m_arm[i] = 1;
            if (bus.load) m_sh[i] = int'(bus.data_preset);
            else if (bus.cen) m_sh[i] = bus.count_up_dwn ? (base + 1) % 16 : (base + 15) % 16;
            else m_sh[i] = base;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("i%0d armed", i),      armed_o[i], m_arm[i]);
         chk($sformatf("i%0d err_count", i),  ec_o[i],    m_ec[i]);
         chk($sformatf("i%0d err_dec", i),    ed_o[i],    m_ed[i]);
         chk($sformatf("i%0d err_tercnt", i), et_o[i],    m_et[i]);
         chk($sformatf("i%0d err_seen", i),   seen_o[i],  m_seen[i]);
         chk($sformatf("i%0d err_cnt", i),    cnt_o[i],   m_cnt[i]);
         chk($sformatf("i%0d first_exp", i),  fe_o[i],    m_fe[i]);
         chk($sformatf("i%0d first_got", i),  fg_o[i],    m_fg[i]);
      end
   endtask

   // Bench-side DUT: a correct counter with optional decode/tercnt corruption.
   task automatic step();
      logic [15:0] dec;
      logic        tc;
      dec = 16'h1 << dut_ctr;
      if (bad_dec) dec = dec | (16'h1 << ((dut_ctr + 3) % 16));
      tc = bus.count_up_dwn ? (dut_ctr == 15) : (dut_ctr == 0);
      if (inv_t) tc = !tc;
      bus.dut_count     = dut_ctr[W-1:0];
      bus.dut_count_dec = dec;
      bus.dut_tercnt    = tc;
      model_edge();
      if (!rst_n) dut_ctr = 0;
      else if (bus.load) dut_ctr = int'(bus.data_preset);
      else if (bus.cen) dut_ctr = bus.count_up_dwn ? (dut_ctr + 1) % 16 : (dut_ctr + 15) % 16;
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 1, 0, 0);
      step();
      step();
      chk("reset armed", armed_o[0], 0);
      rst_n = 1'b1;
      step();
      chk("armed after release", armed_o[0], 1);
      repeat (4) step();

      drive(1, 1, 0, 0);
      repeat (20) step();
      chk("up run err_cnt", cnt_o[0], 0);

      drive(1, 0, 1, 13);
      step();
      drive(1, 0, 0, 0);
      repeat (16) step();
      chk("down run err_seen", seen_o[0], 0);

      drive(0, 1, 1, 5);
      step();
      drive(1, 1, 0, 0);
      dut_ctr = 7;
      step();
      chk("glitch err_count", ec_o[0], 1);
      chk("glitch err_dec", ed_o[0], 1);
      chk("glitch err_cnt", cnt_o[0], 1);
      chk("glitch first_exp", fe_o[0], 5);
      chk("glitch first_got", fg_o[0], 7);
      step();
      chk("resync clears err_count", ec_o[0], 0);
      chk("freerun keeps err_count", ec_o[1], 1);
      repeat (3) step();
      chk("resync err_cnt stable", cnt_o[0], 1);
      chk("freerun err_count still", ec_o[1], 1);

      bad_dec = 1;
      inv_t   = 1;
      step();
      bad_dec = 0;
      inv_t   = 0;
      chk("two-hot err_dec", ed_o[0], 1);
      chk("inv err_tercnt", et_o[0], 1);
      chk("count ok err_count", ec_o[0], 0);
      chk("err_cnt by one", cnt_o[0], 2);
      chk("err_seen held", seen_o[0], 1);
      step();
      chk("err_dec not sticky", ed_o[0], 0);

      rst_n = 1'b0;
      step();
      chk("midrun reset err_cnt", cnt_o[1], 0);
      chk("midrun reset seen", seen_o[1], 0);
      chk("midrun reset armed", armed_o[0], 0);
      rst_n = 1'b1;
      step();
      chk("rearm", armed_o[1], 1);

      repeat (400) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 9) == 0,
               $urandom_range(0, 15));
         rst_n   = ($urandom_range(0, 49) != 0);
         bad_dec = ($urandom_range(0, 29) == 0);
         inv_t   = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 24) == 0) dut_ctr = $urandom_range(0, 15);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dw03_bictr_decode_chk.md
Name: dw03_bictr_decode_chk

Overview:
- Synthesizable checker on the receiving end of the up/down counter-with-decode interface.
- Snoops the same control stimulus as the counter DUT: cen, count_up_dwn, load, data_preset.
- Runs a shadow model of the counter and compares the DUT's count, one-hot decode and terminal-count outputs against it every clock.
- Reports per-cycle mismatch flags, a sticky error, a saturating error counter and first-error capture; sits beside the DUT in the debug bench.

Parameters:
- WIDTH, 8: counter width in bits; decode width is 2**WIDTH.
- ERRW, 16: width of the error counter.
- RESYNC, 1: 1 = on a count mismatch the shadow reloads from dut_count; 0 = the shadow free-runs.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- cen  input  1  count enable, as driven to the DUT.
- count_up_dwn  input  1  direction: 1 = up, 0 = down.
- load  input  1  preset command, active-high, priority over counting.
- data_preset  input  WIDTH  preset value.
- dut_count  input  WIDTH  DUT registered count.
- dut_count_dec  input  2**WIDTH  DUT one-hot decode of count.
- dut_tercnt  input  1  DUT terminal count.
- armed  output  1  checks active.
- err_count  output  1  registered count-mismatch flag.
- err_dec  output  1  registered decode-mismatch flag.
- err_tercnt  output  1  registered tercnt-mismatch flag.
- err_seen  output  1  sticky OR of all error flags.
- err_cnt  output  ERRW  number of cycles with at least one mismatch; saturates.
- first_exp  output  WIDTH  shadow count at the first error.
- first_got  output  WIDTH  dut_count at the first error.

Behaviour:
- Reset (rst_n=0 at posedge):
  - shadow=0, armed=0, all err_* =0, err_seen=0, err_cnt=0, first_exp=0, first_got=0.
  - Reset mid-operation clears everything identically; there is no partial state.
- Arming: armed goes to 1 at the first posedge with rst_n=1 and stays 1 until the next reset. No compares occur while armed=0.
- Shadow update at each posedge with rst_n=1, in priority order:
  1. load=1: shadow <= data_preset (cen and direction ignored).
  2. Else cen=1 and count_up_dwn=1: shadow <= shadow+1, wrapping modulo 2**WIDTH (all-ones -> 0).
  3. Else cen=1 and count_up_dwn=0: shadow <= shadow-1, wrapping (0 -> all-ones).
  4. Else cen=0: hold.
- Expected values, combinational from the current shadow:
  - exp_dec = one-hot with bit[shadow]=1 and all other bits 0.
  - exp_tercnt = 1 when (count_up_dwn=1 and shadow=all-ones) or (count_up_dwn=0 and shadow=0); otherwise 0.
- Compare: at each posedge with armed=1, the current dut_* values are compared with the current shadow/expected values (pre-update).
  - Results are registered, so a mismatch on the DUT outputs in cycle N shows on err_* in cycle N+1.
  - Each err_* flag is high for exactly the cycles that mismatched; flags are not sticky.
- Error accounting:
  - err_seen is set on any flag and cleared only by reset.
  - err_cnt increments by 1 per cycle with any mismatch (not per flag) and holds at 2**ERRW-1.
  - first_exp/first_got load only on the first mismatching cycle after reset, then freeze.
- Resync (RESYNC=1): in a count-mismatch cycle, the shadow's next value is computed from dut_count instead of shadow, using the same load/cen/direction rules. A single DUT glitch therefore yields one error, not a cascade. With RESYNC=0 the shadow is unaffected.
- Simultaneous events:
  - load with cen=1: load wins.
  - A mismatch in the same cycle as load still flags; the next shadow is data_preset regardless of RESYNC.
- Widths: all arithmetic is WIDTH-bit unsigned with natural wrap; the decode index uses the full WIDTH bits.

Test Plan (WIDTH=4, ERRW=16, RESYNC=1 unless noted; DUT modelled by the bench):
- Reset, then 5 idle cycles (cen=0) with a correct DUT at 0 -> armed=1 one cycle after release; all err_*=0; err_cnt=0.
- cen=1, up=1 for 20 cycles with a correct DUT -> count 0..15, 0..3; exp_tercnt high only while shadow=15; no errors.
- load=1, data_preset=13, then cen=1, up=0 for 16 cycles -> shadow 13, 12, ..., 0, 15, ...; tercnt expected only at 0; no errors.
- Force dut_count=7 for one cycle while shadow=5 (decode kept consistent with 7):
  - err_count=1 and err_dec=1 exactly one cycle later; err_cnt=1; first_exp=5, first_got=7; err_seen stays 1.
  - With RESYNC=1, no further errors.
  - Rerun with RESYNC=0 and the DUT continuing from 7 -> err_count stays high on every following cycle.
- Drive dut_count_dec with two bits set and dut_tercnt inverted while dut_count is correct -> err_dec=1 and err_tercnt=1, err_count=0; err_cnt increments by 1, not 2.
- Assert rst_n=0 for one cycle after errors have occurred -> all outputs return to 0 at that edge; armed=1 on the next edge.
